// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state, slot constants and slot rotation helpers
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        SWEEP = 3'd2,
        LOAD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SLOT_NONE = 2'd0;
    localparam logic [1:0] SLOT1     = 2'd1;
    localparam logic [1:0] SLOT2     = 2'd2;
    localparam logic [1:0] SLOT3     = 2'd3;

    function automatic logic [1:0] slot_next(input logic [1:0] s);
        case (s)
            SLOT1:   return SLOT2;
            SLOT2:   return SLOT3;
            SLOT3:   return SLOT1;
            default: return SLOT_NONE;
        endcase
    endfunction

    function automatic logic [1:0] slot_prev(input logic [1:0] s);
        case (s)
            SLOT1:   return SLOT3;
            SLOT2:   return SLOT1;
            SLOT3:   return SLOT2;
            default: return SLOT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/conv_row_loader.sv
// rtl/conv_row_loader.sv - accepts one image row of words into a slot, registered write port
module conv_row_loader
    import conv_pkg::*;
#(
    parameter int ADR_W  = 16,
    parameter int WORD_W = 512,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [1:0]        load_slot,
    input  logic [CNT_W-1:0]  load_words,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              row_done,
    output logic [WORD_W-1:0] wr_data,
    output logic              wr_en,
    output logic [1:0]        wr_idx,
    output logic [ADR_W-1:0]  wr_adr
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             active;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] words_q;
    logic [1:0]       slot_q;
    logic             accept;
    logic             last_word;

    assign in_ready  = active;
    assign accept    = active & in_valid;
    assign last_word = (wcnt == words_q - CNT_ONE);
    assign row_done  = accept & last_word;

    // A new load_start may coincide with the previous row's last accept;
    // the accept still captures the old slot, so rows chain with no gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active  <= 1'b0;
            wcnt    <= '0;
            words_q <= '0;
            slot_q  <= SLOT_NONE;
            wr_data <= '0;
            wr_en   <= 1'b0;
            wr_idx  <= SLOT_NONE;
            wr_adr  <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_data <= in_word;
                wr_adr  <= ADR_W'(wcnt);
                wr_idx  <= slot_q;
            end
            if (load_start) begin
                active  <= 1'b1;
                wcnt    <= '0;
                words_q <= load_words;
                slot_q  <= load_slot;
            end else if (accept) begin
                if (last_word) begin
                    active <= 1'b0;
                end else begin
                    wcnt <= wcnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/conv_row_buffer_scheduler.sv
// rtl/conv_row_buffer_scheduler.sv - line buffer fill/sweep/load sequencer for 3x3 pad-1 conv
module conv_row_buffer_scheduler
    import conv_pkg::*;
#(
    parameter int ADR_W  = 16,
    parameter int WORD_W = 512,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_rows,
    input  logic [CNT_W-1:0]  cfg_words,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sweep_stall,
    output logic              busy,
    output logic              done,
    output logic [1:0]        row1_buf_idx,
    output logic [ADR_W-1:0]  row1_buf_adr,
    output logic              row1_buf_word_select,
    output logic [1:0]        row1_slab_idx,
    output logic [ADR_W-1:0]  row1_slab_adr,
    output logic [ADR_W-1:0]  row1_slab_adr_to_wr,
    output logic              valid_row1_adr,
    output logic [1:0]        row2_buf_idx,
    output logic [ADR_W-1:0]  row2_buf_adr,
    output logic              row2_buf_word_select,
    output logic [1:0]        row2_slab_idx,
    output logic [ADR_W-1:0]  row2_slab_adr,
    output logic [ADR_W-1:0]  row2_slab_adr_to_wr,
    output logic              valid_row2_adr,
    output logic [1:0]        row3_buf_idx,
    output logic [ADR_W-1:0]  row3_buf_adr,
    output logic              row3_buf_word_select,
    output logic [1:0]        row3_slab_idx,
    output logic [ADR_W-1:0]  row3_slab_adr,
    output logic [ADR_W-1:0]  row3_slab_adr_to_wr,
    output logic              valid_row3_adr,
    output logic [1:0]        last_row1_buf_idx,
    output logic [1:0]        last_row1_slab_idx,
    output logic [1:0]        last_row2_buf_idx,
    output logic [1:0]        last_row2_slab_idx,
    output logic [1:0]        last_row3_buf_idx,
    output logic [1:0]        last_row3_slab_idx,
    output logic [WORD_W-1:0] input_word_buf_wr,
    output logic              input_word_buf_en_wr,
    output logic [1:0]        input_word_buf_idx_wr,
    output logic [ADR_W-1:0]  input_word_buf_adr_wr
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   BEAT_ONE = (CNT_W + 1)'(1);
    localparam logic [CNT_W:0]   BEAT_TWO = (CNT_W + 1)'(2);

    state_t           state, state_n;
    logic [CNT_W-1:0] rows_q, rows_n;
    logic [CNT_W-1:0] words_q, words_n;
    logic [CNT_W-1:0] y, y_n;
    logic [CNT_W:0]   beat, beat_n;
    logic [1:0]       slot_y, slot_y_n;
    logic             fill_second, fill_second_n;

    logic             load_start;
    logic [1:0]       load_slot;
    logic [CNT_W-1:0] load_words;
    logic             row_done;

    logic             last_beat;
    logic             has_next;
    logic             has_next2;

    assign last_beat = (beat == ({words_q, 1'b0} - BEAT_ONE));
    assign has_next  = (({1'b0, y} + BEAT_ONE) < {1'b0, rows_q});
    assign has_next2 = (({1'b0, y} + BEAT_TWO) < {1'b0, rows_q});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rows_q      <= '0;
            words_q     <= '0;
            y           <= '0;
            beat        <= '0;
            slot_y      <= SLOT_NONE;
            fill_second <= 1'b0;
        end else begin
            state       <= state_n;
            rows_q      <= rows_n;
            words_q     <= words_n;
            y           <= y_n;
            beat        <= beat_n;
            slot_y      <= slot_y_n;
            fill_second <= fill_second_n;
        end
    end

    always_comb begin
        state_n       = state;
        rows_n        = rows_q;
        words_n       = words_q;
        y_n           = y;
        beat_n        = beat;
        slot_y_n      = slot_y;
        fill_second_n = fill_second;
        load_start    = 1'b0;
        load_slot     = SLOT1;
        load_words    = words_q;
        case (state)
            IDLE: begin
                if (start) begin
                    rows_n        = cfg_rows;
                    words_n       = cfg_words;
                    y_n           = '0;
                    beat_n        = '0;
                    slot_y_n      = SLOT1;
                    fill_second_n = 1'b0;
                    if (cfg_rows == '0 || cfg_words == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n    = FILL;
                        load_start = 1'b1;
                        load_slot  = SLOT1;
                        load_words = cfg_words;
                    end
                end
            end
            FILL: begin
                if (row_done) begin
                    if (!fill_second && rows_q != CNT_ONE) begin
                        fill_second_n = 1'b1;
                        load_start    = 1'b1;
                        load_slot     = SLOT2;
                    end else begin
                        state_n  = SWEEP;
                        y_n      = '0;
                        beat_n   = '0;
                        slot_y_n = SLOT1;
                    end
                end
            end
            SWEEP: begin
                if (!sweep_stall) begin
                    if (last_beat) begin
                        beat_n = '0;
                        if (has_next2) begin
                            // Row y+2 reuses the slot of row y-1, which this sweep just retired.
                            state_n    = LOAD;
                            load_start = 1'b1;
                            load_slot  = slot_prev(slot_y);
                        end else if (has_next) begin
                            y_n      = y + CNT_ONE;
                            slot_y_n = slot_next(slot_y);
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        beat_n = beat + BEAT_ONE;
                    end
                end
            end
            LOAD: begin
                if (row_done) begin
                    state_n  = SWEEP;
                    y_n      = y + CNT_ONE;
                    slot_y_n = slot_next(slot_y);
                    beat_n   = '0;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    logic             row_ok      [1:3];
    logic [1:0]       row_slot    [1:3];
    logic [1:0]       o_idx       [1:3];
    logic [ADR_W-1:0] o_adr       [1:3];
    logic             o_ws        [1:3];
    logic [1:0]       o_slab_idx  [1:3];
    logic [ADR_W-1:0] o_slab_adr  [1:3];
    logic [ADR_W-1:0] o_slab_wr   [1:3];
    logic             o_valid     [1:3];

    always_comb begin
        row_ok[1]   = (state == SWEEP) && (y != '0);
        row_ok[2]   = (state == SWEEP);
        row_ok[3]   = (state == SWEEP) && has_next;
        row_slot[1] = slot_prev(slot_y);
        row_slot[2] = slot_y;
        row_slot[3] = slot_next(slot_y);
        for (int k = 1; k <= 3; k++) begin
            o_idx[k]      = SLOT_NONE;
            o_adr[k]      = '0;
            o_ws[k]       = 1'b0;
            o_slab_idx[k] = SLOT_NONE;
            o_slab_adr[k] = '0;
            o_slab_wr[k]  = '0;
            o_valid[k]    = 1'b0;
            if (row_ok[k]) begin
                o_idx[k]     = row_slot[k];
                o_adr[k]     = ADR_W'(beat >> 1);
                o_ws[k]      = beat[0];
                o_slab_wr[k] = ADR_W'(beat);
                o_valid[k]   = !sweep_stall;
                // Beat 0 has no previous slab column to read back.
                if (beat != '0) begin
                    o_slab_idx[k] = row_slot[k];
                    o_slab_adr[k] = ADR_W'(beat - BEAT_ONE);
                end
            end
        end
    end

    assign row1_buf_idx         = o_idx[1];
    assign row1_buf_adr         = o_adr[1];
    assign row1_buf_word_select = o_ws[1];
    assign row1_slab_idx        = o_slab_idx[1];
    assign row1_slab_adr        = o_slab_adr[1];
    assign row1_slab_adr_to_wr  = o_slab_wr[1];
    assign valid_row1_adr       = o_valid[1];
    assign row2_buf_idx         = o_idx[2];
    assign row2_buf_adr         = o_adr[2];
    assign row2_buf_word_select = o_ws[2];
    assign row2_slab_idx        = o_slab_idx[2];
    assign row2_slab_adr        = o_slab_adr[2];
    assign row2_slab_adr_to_wr  = o_slab_wr[2];
    assign valid_row2_adr       = o_valid[2];
    assign row3_buf_idx         = o_idx[3];
    assign row3_buf_adr         = o_adr[3];
    assign row3_buf_word_select = o_ws[3];
    assign row3_slab_idx        = o_slab_idx[3];
    assign row3_slab_adr        = o_slab_adr[3];
    assign row3_slab_adr_to_wr  = o_slab_wr[3];
    assign valid_row3_adr       = o_valid[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_row1_buf_idx  <= SLOT_NONE;
            last_row1_slab_idx <= SLOT_NONE;
            last_row2_buf_idx  <= SLOT_NONE;
            last_row2_slab_idx <= SLOT_NONE;
            last_row3_buf_idx  <= SLOT_NONE;
            last_row3_slab_idx <= SLOT_NONE;
        end else begin
            last_row1_buf_idx  <= o_idx[1];
            last_row1_slab_idx <= o_slab_idx[1];
            last_row2_buf_idx  <= o_idx[2];
            last_row2_slab_idx <= o_slab_idx[2];
            last_row3_buf_idx  <= o_idx[3];
            last_row3_slab_idx <= o_slab_idx[3];
        end
    end

    conv_row_loader #(
        .ADR_W (ADR_W),
        .WORD_W(WORD_W),
        .CNT_W (CNT_W)
    ) u_loader (
        .clk       (clk),
        .reset     (reset),
        .load_start(load_start),
        .load_slot (load_slot),
        .load_words(load_words),
        .in_word   (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .row_done  (row_done),
        .wr_data   (input_word_buf_wr),
        .wr_en     (input_word_buf_en_wr),
        .wr_idx    (input_word_buf_idx_wr),
        .wr_adr    (input_word_buf_adr_wr)
    );

endmodule

// File: tb/tb_conv_row_buffer_scheduler.sv
// tb/tb_conv_row_buffer_scheduler.sv - randomized bench with frame-level reference model
module tb_conv_row_buffer_scheduler;

    localparam int ADR_W  = 16;
    localparam int WORD_W = 512;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  cfg_rows = '0;
    logic [CNT_W-1:0]  cfg_words = '0;
    logic [WORD_W-1:0] in_word = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              sweep_stall = 1'b0;
    logic              busy, done;
    logic [1:0]        row1_buf_idx, row2_buf_idx, row3_buf_idx;
    logic [ADR_W-1:0]  row1_buf_adr, row2_buf_adr, row3_buf_adr;
    logic              row1_buf_word_select, row2_buf_word_select, row3_buf_word_select;
    logic [1:0]        row1_slab_idx, row2_slab_idx, row3_slab_idx;
    logic [ADR_W-1:0]  row1_slab_adr, row2_slab_adr, row3_slab_adr;
    logic [ADR_W-1:0]  row1_slab_adr_to_wr, row2_slab_adr_to_wr, row3_slab_adr_to_wr;
    logic              valid_row1_adr, valid_row2_adr, valid_row3_adr;
    logic [1:0]        last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx;
    logic [1:0]        last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx;
    logic [WORD_W-1:0] input_word_buf_wr;
    logic              input_word_buf_en_wr;
    logic [1:0]        input_word_buf_idx_wr;
    logic [ADR_W-1:0]  input_word_buf_adr_wr;

    always #5 clk = ~clk;

    conv_row_buffer_scheduler #(.ADR_W(ADR_W), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows), .cfg_words(cfg_words),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready), .sweep_stall(sweep_stall),
        .busy(busy), .done(done),
        .row1_buf_idx(row1_buf_idx), .row1_buf_adr(row1_buf_adr),
        .row1_buf_word_select(row1_buf_word_select), .row1_slab_idx(row1_slab_idx),
        .row1_slab_adr(row1_slab_adr), .row1_slab_adr_to_wr(row1_slab_adr_to_wr),
        .valid_row1_adr(valid_row1_adr),
        .row2_buf_idx(row2_buf_idx), .row2_buf_adr(row2_buf_adr),
        .row2_buf_word_select(row2_buf_word_select), .row2_slab_idx(row2_slab_idx),
        .row2_slab_adr(row2_slab_adr), .row2_slab_adr_to_wr(row2_slab_adr_to_wr),
        .valid_row2_adr(valid_row2_adr),
        .row3_buf_idx(row3_buf_idx), .row3_buf_adr(row3_buf_adr),
        .row3_buf_word_select(row3_buf_word_select), .row3_slab_idx(row3_slab_idx),
        .row3_slab_adr(row3_slab_adr), .row3_slab_adr_to_wr(row3_slab_adr_to_wr),
        .valid_row3_adr(valid_row3_adr),
        .last_row1_buf_idx(last_row1_buf_idx), .last_row1_slab_idx(last_row1_slab_idx),
        .last_row2_buf_idx(last_row2_buf_idx), .last_row2_slab_idx(last_row2_slab_idx),
        .last_row3_buf_idx(last_row3_buf_idx), .last_row3_slab_idx(last_row3_slab_idx),
        .input_word_buf_wr(input_word_buf_wr), .input_word_buf_en_wr(input_word_buf_en_wr),
        .input_word_buf_idx_wr(input_word_buf_idx_wr), .input_word_buf_adr_wr(input_word_buf_adr_wr)
    );

    typedef struct { int y; int b; } beat_t;

    int checks = 0;
    int errors = 0;
    beat_t             exp_beats[$];
    logic [WORD_W-1:0] acc_q[$];
    int  rows, words, n_written, n_acc, popped, stall_hold, stall_at;
    bit  pend, exp_done, exp_busy, got_done, last_known, rnd_stall;
    logic [1:0] prev_idx[3];
    logic [1:0] prev_slab[3];

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_check(input string t);
        chk({t, "_ctrl"}, {busy, done, in_ready, valid_row1_adr, valid_row2_adr, valid_row3_adr,
                           input_word_buf_en_wr}, '0);
        chk({t, "_idx"}, {row1_buf_idx, row2_buf_idx, row3_buf_idx, row1_slab_idx, row2_slab_idx,
                          row3_slab_idx, last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx,
                          last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx}, '0);
        chk({t, "_adr"}, {row1_buf_adr, row2_buf_adr, row3_buf_adr, row1_slab_adr, row2_slab_adr,
                          row3_slab_adr, row1_slab_adr_to_wr, row2_slab_adr_to_wr, row3_slab_adr_to_wr,
                          row1_buf_word_select, row2_buf_word_select, row3_buf_word_select}, '0);
        chk({t, "_wr"}, {input_word_buf_wr, input_word_buf_adr_wr, input_word_buf_idx_wr}, '0);
    endtask

    task automatic model_clear();
        exp_beats.delete();
        acc_q.delete();
        n_written = 0; n_acc = 0; popped = 0; stall_hold = 0;
        pend = 0; exp_done = 0; exp_busy = 0; got_done = 0; last_known = 0;
    endtask

    task automatic step(input bit st, input bit new_frame, input logic [15:0] cr, input logic [15:0] cw);
        logic [1:0]  oi[3], osi[3], oli[3], olsi[3];
        logic [15:0] oa[3], osa[3], ow[3];
        logic        ows[3], ov[3];
        bit  acc, cur_known, ok;
        beat_t bt;
        int  r, ei, exp_wr;
        @(negedge clk);
        start = st; cfg_rows = cr; cfg_words = cw;
        if (stall_hold > 0) begin
            sweep_stall = 1'b1;
            stall_hold--;
        end else begin
            sweep_stall = rnd_stall && ($urandom_range(0, 4) == 0);
        end
        in_valid = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < WORD_W / 32; i++) in_word[i*32 +: 32] = $urandom;
        #1;
        oi  = '{row1_buf_idx, row2_buf_idx, row3_buf_idx};
        osi = '{row1_slab_idx, row2_slab_idx, row3_slab_idx};
        oli = '{last_row1_buf_idx, last_row2_buf_idx, last_row3_buf_idx};
        olsi = '{last_row1_slab_idx, last_row2_slab_idx, last_row3_slab_idx};
        oa  = '{row1_buf_adr, row2_buf_adr, row3_buf_adr};
        osa = '{row1_slab_adr, row2_slab_adr, row3_slab_adr};
        ow  = '{row1_slab_adr_to_wr, row2_slab_adr_to_wr, row3_slab_adr_to_wr};
        ows = '{row1_buf_word_select, row2_buf_word_select, row3_buf_word_select};
        ov  = '{valid_row1_adr, valid_row2_adr, valid_row3_adr};

        chk("done", done, exp_done);
        chk("busy", busy, exp_busy);
        if (done) got_done = 1;
        exp_done = 0;
        if (!exp_busy) chk("idle_ready", in_ready, 1'b0);

        chk("en_wr", input_word_buf_en_wr, pend);
        if (pend) begin
            chk("wr_data", input_word_buf_wr, acc_q.pop_front());
            chk("wr_adr", input_word_buf_adr_wr, n_written % words);
            chk("wr_idx", input_word_buf_idx_wr, ((n_written / words) % 3) + 1);
            n_written++;
        end

        if (sweep_stall) chk("stall_valid", {ov[0], ov[1], ov[2]}, '0);

        if (last_known) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("last_buf_idx%0d", k + 1), oli[k], prev_idx[k]);
                chk($sformatf("last_slab_idx%0d", k + 1), olsi[k], prev_slab[k]);
            end
        end

        cur_known = 0;
        if (ov[1]) begin
            if (exp_beats.size() == 0) begin
                chk("extra_beat", ov[1], 1'b0);
            end else begin
                bt = exp_beats.pop_front();
                popped++;
                exp_wr = ((bt.y + 2 < rows) ? bt.y + 2 : rows) * words;
                chk($sformatf("rows_loaded_y%0d", bt.y), n_written, exp_wr);
                for (int k = 0; k < 3; k++) begin
                    r  = bt.y - 1 + k;
                    ok = (k == 0) ? (bt.y >= 1) : (k == 1) ? 1'b1 : (bt.y + 1 < rows);
                    ei = ok ? (r % 3) + 1 : 0;
                    prev_idx[k]  = 2'(ei);
                    prev_slab[k] = (ok && bt.b != 0) ? 2'(ei) : 2'd0;
                    chk($sformatf("beat_y%0d_b%0d_row%0d", bt.y, bt.b, k + 1),
                        {oi[k], oa[k], ows[k], osi[k], osa[k], ow[k], ov[k]},
                        {2'(ei), ok ? 16'(bt.b / 2) : 16'd0, ok && (bt.b % 2 == 1), prev_slab[k],
                         (ok && bt.b != 0) ? 16'(bt.b - 1) : 16'd0, ok ? 16'(bt.b) : 16'd0, ok});
                end
                cur_known = 1;
                if (popped == stall_at) stall_hold = 3;
                if (exp_beats.size() == 0) exp_done = 1;
            end
        end

        acc = in_valid && in_ready;
        if (acc) begin
            chk("overrun", (n_acc < rows * words), 1'b1);
            acc_q.push_back(in_word);
            n_acc++;
        end
        pend = acc;
        if (new_frame) begin
            exp_busy = 1;
            if (cr == 0 || cw == 0) exp_done = 1;
        end
        if (done) exp_busy = 0;
        last_known = cur_known;
    endtask

    task automatic frame_setup(input int r, input int w, input int sat, input bit rs);
        rows = r; words = w; stall_at = sat; rnd_stall = rs;
        n_written = 0; n_acc = 0; popped = 0; got_done = 0;
        exp_beats.delete();
        acc_q.delete();
        if (r > 0 && w > 0)
            for (int yy = 0; yy < r; yy++)
                for (int b = 0; b < 2 * w; b++) exp_beats.push_back('{y: yy, b: b});
        step(1'b1, 1'b1, 16'(r), 16'(w));
    endtask

    task automatic run_frame(input int r, input int w, input int sat, input bit rs);
        frame_setup(r, w, sat, rs);
        for (int c = 0; c < 4000 && !got_done; c++)
            step(($urandom_range(0, 15) == 0), 1'b0, 16'($urandom), 16'($urandom));
        chk($sformatf("frame_done_r%0d_w%0d", r, w), got_done, 1'b1);
        chk($sformatf("frame_words_r%0d_w%0d", r, w), n_written, (r > 0 && w > 0) ? r * w : 0);
        chk($sformatf("frame_beats_r%0d_w%0d", r, w), exp_beats.size(), 0);
    endtask

    initial begin
        model_clear();
        @(negedge clk);
        #1;
        zero_check("reset");
        @(negedge clk);
        reset = 1'b1;

        run_frame(1, 1, -1, 1'b0);
        run_frame(4, 2, -1, 1'b0);
        run_frame(3, 2, 3, 1'b0);
        run_frame(2, 1, -1, 1'b1);
        run_frame(0, 3, -1, 1'b0);
        run_frame(5, 0, -1, 1'b0);

        frame_setup(5, 2, -1, 1'b0);
        for (int c = 0; c < 500 && popped < 4; c++) step(1'b0, 1'b0, 16'd0, 16'd0);
        chk("reach_load", popped, 4);
        step(1'b0, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        sweep_stall = 1'b0;
        #1;
        zero_check("midload_reset");
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        run_frame(3, 2, -1, 1'b0);

        for (int i = 0; i < 6; i++)
            run_frame($urandom_range(1, 6), $urandom_range(1, 4), -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
